// File: rtl/brdg_retry_replay.sv
// Replays a logged AFU command when a retry arrives; replay is presented 3 cycles after acceptance and held until rpl_rdy.
// Optional per-tag replay limit with abort pulse is enabled by defining RETRY_LIMIT_EN.
module brdg_retry_replay #(
  parameter int TAGW = 7,
  parameter int AW   = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            log_wr,
  input  logic [TAGW-1:0] log_tag,
  input  logic [AW-1:0]   log_addr,
  input  logic [1:0]      log_dl,
  input  logic            log_wrcmd,
  input  logic            log_split,
  input  logic            rty_valid,
  output logic            rty_rdy,
  input  logic [TAGW-1:0] rty_tag,
  input  logic [1:0]      rty_pos,
  output logic            rpl_valid,
  input  logic            rpl_rdy,
  output logic [TAGW-1:0] rpl_tag,
  output logic [AW-1:0]   rpl_addr,
  output logic [1:0]      rpl_dl,
  output logic            rpl_wrcmd,
`ifdef RETRY_LIMIT_EN
  output logic            rpl_abort,
  output logic [TAGW-1:0] rpl_abort_tag,
  input  logic [3:0]      retry_max,
`endif
  output logic            rpl_busy
);

  localparam int EW    = AW + 4;
  localparam int DEPTH = 1 << TAGW;

  typedef enum logic [4:0] {
    IDLE   = 5'b00001,
    LOOKUP = 5'b00010,
    BUILD  = 5'b00100,
    ISSUE  = 5'b01000,
    ABORT  = 5'b10000
  } state_e;

  state_e          state_q, state_d;
  logic [TAGW-1:0] tag_q;
  logic [1:0]      pos_q;
  logic [EW-1:0]   rd_q;
  logic [TAGW-1:0] rpl_tag_q;
  logic [AW-1:0]   rpl_addr_q;
  logic [1:0]      rpl_dl_q;
  logic            rpl_wrcmd_q;
  logic            abort_hit;

  logic [EW-1:0]   mem [0:DEPTH-1];
  logic [EW-1:0]   log_ent;
  logic [AW-1:0]   rd_addr;
  logic [1:0]      rd_dl;
  logic            rd_wrcmd;
  logic            rd_split;
  logic [AW-1:0]   pos_off;

  assign log_ent = {log_addr, log_dl, log_wrcmd, log_split};
  assign {rd_addr, rd_dl, rd_wrcmd, rd_split} = rd_q;

  always_ff @(posedge clk) begin
    if (log_wr) mem[log_tag] <= log_ent;
  end

  always_comb begin
    pos_off      = '0;
    pos_off[7:6] = pos_q;
  end

  // Write-first: a log write to the tag being looked up wins over stale RAM data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= '0;
    end else if (state_q == LOOKUP) begin
      rd_q <= (log_wr && (log_tag == tag_q)) ? log_ent : mem[tag_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tag_q       <= '0;
      pos_q       <= '0;
      rpl_tag_q   <= '0;
      rpl_addr_q  <= '0;
      rpl_dl_q    <= '0;
      rpl_wrcmd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (rty_valid && rty_rdy) begin
        tag_q <= rty_tag;
        pos_q <= rty_pos;
      end
      if (state_q == BUILD) begin
        rpl_tag_q   <= tag_q;
        rpl_addr_q  <= rd_split ? (rd_addr + pos_off) : rd_addr;
        rpl_dl_q    <= rd_split ? 2'd1 : rd_dl;
        rpl_wrcmd_q <= rd_wrcmd;
      end
    end
  end

`ifdef RETRY_LIMIT_EN
  logic [3:0]      cnt_q [0:DEPTH-1];
  logic [TAGW-1:0] abort_tag_q;

  assign abort_hit = (state_q == BUILD) && (cnt_q[tag_q] == retry_max);

  // A fresh log of the same tag overrides a concurrent completion increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) cnt_q[i] <= 4'd0;
      abort_tag_q <= '0;
    end else begin
      if ((state_q == ISSUE) && rpl_rdy && (cnt_q[rpl_tag_q] != 4'hF))
        cnt_q[rpl_tag_q] <= cnt_q[rpl_tag_q] + 4'd1;
      if (log_wr) cnt_q[log_tag] <= 4'd0;
      if (abort_hit) abort_tag_q <= tag_q;
    end
  end

  assign rpl_abort     = (state_q == ABORT);
  assign rpl_abort_tag = abort_tag_q;
`else
  assign abort_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rty_valid) state_d = LOOKUP;
      LOOKUP:  state_d = BUILD;
      BUILD:   state_d = abort_hit ? ABORT : ISSUE;
      ISSUE:   if (rpl_rdy) state_d = IDLE;
      ABORT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign rty_rdy   = (state_q == IDLE);
  assign rpl_busy  = (state_q != IDLE);
  assign rpl_valid = (state_q == ISSUE);
  assign rpl_tag   = rpl_tag_q;
  assign rpl_addr  = rpl_addr_q;
  assign rpl_dl    = rpl_dl_q;
  assign rpl_wrcmd = rpl_wrcmd_q;

endmodule

// File: tb/tb_brdg_retry_replay.sv
// Directed bench for brdg_retry_replay: logged commands modelled in the bench, replays checked from a scoreboard queue.
// Abort scenario is exercised only when RETRY_LIMIT_EN is defined.
module tb_brdg_retry_replay;

  logic        clk;
  logic        rst_n;
  logic        log_wr;
  logic [6:0]  log_tag;
  logic [63:0] log_addr;
  logic [1:0]  log_dl;
  logic        log_wrcmd;
  logic        log_split;
  logic        rty_valid;
  logic        rty_rdy;
  logic [6:0]  rty_tag;
  logic [1:0]  rty_pos;
  logic        rpl_valid;
  logic        rpl_rdy;
  logic [6:0]  rpl_tag;
  logic [63:0] rpl_addr;
  logic [1:0]  rpl_dl;
  logic        rpl_wrcmd;
  logic        rpl_busy;
`ifdef RETRY_LIMIT_EN
  logic        rpl_abort;
  logic [6:0]  rpl_abort_tag;
  logic [3:0]  retry_max;
`endif

  brdg_retry_replay #(.TAGW(7), .AW(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .log_wr(log_wr), .log_tag(log_tag), .log_addr(log_addr), .log_dl(log_dl),
    .log_wrcmd(log_wrcmd), .log_split(log_split),
    .rty_valid(rty_valid), .rty_rdy(rty_rdy), .rty_tag(rty_tag), .rty_pos(rty_pos),
    .rpl_valid(rpl_valid), .rpl_rdy(rpl_rdy), .rpl_tag(rpl_tag), .rpl_addr(rpl_addr),
    .rpl_dl(rpl_dl), .rpl_wrcmd(rpl_wrcmd),
`ifdef RETRY_LIMIT_EN
    .rpl_abort(rpl_abort), .rpl_abort_tag(rpl_abort_tag), .retry_max(retry_max),
`endif
    .rpl_busy(rpl_busy)
  );

  typedef struct packed {
    logic [6:0]  tag;
    logic [63:0] addr;
    logic [1:0]  dl;
    logic        wrcmd;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] m_addr  [0:127];
  logic [1:0]  m_dl    [0:127];
  logic        m_wr    [0:127];
  logic        m_split [0:127];
  int          n_chk = 0;
  int          n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic exp_t mk_exp(input logic [6:0] t, input logic [1:0] p);
    exp_t e;
    e.tag   = t;
    e.wrcmd = m_wr[t];
    if (m_split[t]) begin
      e.addr = m_addr[t] + {56'd0, p, 6'd0};
      e.dl   = 2'd1;
    end else begin
      e.addr = m_addr[t];
      e.dl   = m_dl[t];
    end
    return e;
  endfunction

  task automatic chk_fields(input string pfx, input exp_t e);
    chk({pfx, "_tag"},   64'(rpl_tag),   64'(e.tag));
    chk({pfx, "_addr"},  rpl_addr,       e.addr);
    chk({pfx, "_dl"},    64'(rpl_dl),    64'(e.dl));
    chk({pfx, "_wrcmd"}, 64'(rpl_wrcmd), 64'(e.wrcmd));
  endtask

  task automatic drive_log(input logic [6:0] t, input logic [63:0] a, input logic [1:0] dl,
                           input logic wr, input logic sp);
    log_wr = 1'b1; log_tag = t; log_addr = a; log_dl = dl; log_wrcmd = wr; log_split = sp;
    m_addr[t] = a; m_dl[t] = dl; m_wr[t] = wr; m_split[t] = sp;
  endtask

  task automatic log_cmd(input logic [6:0] t, input logic [63:0] a, input logic [1:0] dl,
                         input logic wr, input logic sp);
    drive_log(t, a, dl, wr, sp);
    tick();
    log_wr = 1'b0;
  endtask

  // lk_wr drives a log write during the LOOKUP cycle (same tag exercises the bypass).
  task automatic do_retry(input logic [6:0] t, input logic [1:0] p, input int hold,
                          input bit lk_wr, input logic [6:0] lk_tag, input logic [63:0] lk_addr,
                          input logic [1:0] lk_dl, input logic lk_split);
    exp_t e;
    chk("idle_rty_rdy", 64'(rty_rdy), 64'd1);
    rty_valid = 1'b1; rty_tag = t; rty_pos = p;
    tick();
    rty_valid = 1'b0;
    if (lk_wr) drive_log(lk_tag, lk_addr, lk_dl, 1'b0, lk_split);
    sb.push_back(mk_exp(t, p));
    chk("lookup_vld", 64'(rpl_valid), 64'd0);
    chk("lookup_busy", 64'(rpl_busy), 64'd1);
    tick();
    log_wr = 1'b0;
    chk("build_vld", 64'(rpl_valid), 64'd0);
    tick();
    chk("issue_vld", 64'(rpl_valid), 64'd1);
    for (int i = 0; i < hold; i++) begin
      rty_valid = 1'b1; rty_tag = t ^ 7'd1;
      chk("hold_rty_rdy", 64'(rty_rdy), 64'd0);
      chk_fields("hold", sb[0]);
      tick();
      chk("hold_vld", 64'(rpl_valid), 64'd1);
    end
    rty_valid = 1'b0;
    rpl_rdy = 1'b1;
    e = sb.pop_front();
    chk_fields("rpl", e);
    tick();
    rpl_rdy = 1'b0;
    chk("done_vld", 64'(rpl_valid), 64'd0);
    chk("done_rty_rdy", 64'(rty_rdy), 64'd1);
  endtask

`ifdef RETRY_LIMIT_EN
  task automatic do_abort(input logic [6:0] t);
    chk("ab_rty_rdy", 64'(rty_rdy), 64'd1);
    rty_valid = 1'b1; rty_tag = t; rty_pos = 2'd0;
    tick();
    rty_valid = 1'b0;
    tick();
    tick();
    chk("ab_pulse", 64'(rpl_abort), 64'd1);
    chk("ab_tag", 64'(rpl_abort_tag), 64'(t));
    chk("ab_no_vld", 64'(rpl_valid), 64'd0);
    tick();
    chk("ab_pulse_end", 64'(rpl_abort), 64'd0);
    chk("ab_end_vld", 64'(rpl_valid), 64'd0);
    chk("ab_end_rdy", 64'(rty_rdy), 64'd1);
  endtask
`endif

  initial begin
    rst_n = 1'b0; log_wr = 1'b0; log_tag = '0; log_addr = '0; log_dl = '0;
    log_wrcmd = 1'b0; log_split = 1'b0; rty_valid = 1'b0; rty_tag = '0; rty_pos = '0;
    rpl_rdy = 1'b0;
`ifdef RETRY_LIMIT_EN
    retry_max = 4'd15;
`endif
    #12;
    chk("rst_vld",   64'(rpl_valid), 64'd0);
    chk("rst_busy",  64'(rpl_busy),  64'd0);
    chk("rst_rdy",   64'(rty_rdy),   64'd1);
    chk("rst_tag",   64'(rpl_tag),   64'd0);
    chk("rst_addr",  rpl_addr,       64'd0);
    chk("rst_dl",    64'(rpl_dl),    64'd0);
    chk("rst_wrcmd", 64'(rpl_wrcmd), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Non-split: position ignored
    log_cmd(7'd5, 64'h1000, 2'd3, 1'b1, 1'b0);
    do_retry(7'd5, 2'd2, 0, 1'b0, 7'd0, 64'd0, 2'd0, 1'b0);

    // Split: offset carries into bit 12
    log_cmd(7'd9, 64'h0FC0, 2'd2, 1'b0, 1'b1);
    do_retry(7'd9, 2'd3, 0, 1'b0, 7'd0, 64'd0, 2'd0, 1'b0);

    // Split: offset wraps the full address width
    log_cmd(7'd10, 64'hFFFF_FFFF_FFFF_FFC0, 2'd3, 1'b1, 1'b1);
    do_retry(7'd10, 2'd1, 0, 1'b0, 7'd0, 64'd0, 2'd0, 1'b0);

    // Backpressure for 10 cycles with a competing retry request
    do_retry(7'd5, 2'd0, 10, 1'b0, 7'd0, 64'd0, 2'd0, 1'b0);
    tick();
    chk("no_second_accept", 64'(rpl_busy), 64'd0);

    // Same-tag write during LOOKUP is returned by the read
    log_cmd(7'd4, 64'h3000, 2'd2, 1'b1, 1'b0);
    do_retry(7'd4, 2'd1, 0, 1'b1, 7'd4, 64'h2000, 2'd1, 1'b0);

    // Different-tag write during LOOKUP must not disturb the read
    do_retry(7'd9, 2'd0, 0, 1'b1, 7'd8, 64'h7777_0000, 2'd3, 1'b0);

`ifdef RETRY_LIMIT_EN
    retry_max = 4'd2;
    log_cmd(7'd3, 64'h5000, 2'd2, 1'b0, 1'b0);
    do_retry(7'd3, 2'd0, 0, 1'b0, 7'd0, 64'd0, 2'd0, 1'b0);
    do_retry(7'd3, 2'd0, 0, 1'b0, 7'd0, 64'd0, 2'd0, 1'b0);
    do_abort(7'd3);
    retry_max = 4'd15;
`endif

    // Reset while ISSUE is waiting for rpl_rdy
    log_cmd(7'd12, 64'h4440, 2'd2, 1'b0, 1'b0);
    rty_valid = 1'b1; rty_tag = 7'd12; rty_pos = 2'd0;
    tick();
    rty_valid = 1'b0;
    tick();
    tick();
    chk("pre_rst_vld", 64'(rpl_valid), 64'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_vld", 64'(rpl_valid), 64'd0);
    chk("async_rst_addr", rpl_addr, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_rdy",  64'(rty_rdy),   64'd1);
    chk("post_rst_busy", 64'(rpl_busy),  64'd0);
    chk("post_rst_vld",  64'(rpl_valid), 64'd0);
    chk("sb_empty",      64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1);
  end

endmodule
